id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and operand-delivery stage directly upstream of the EX-stage ALU.
//  - Captures decoded fields and control bits; registers the 4-bit ALU control code.
//  - Applies EX/MEM and MEM/WB forwarding; presents final data1/data2/ALUCtrl to the ALU.
//  - Detects load-use hazards and self-inserts the required bubble.
// PARAMETERS
//  XLEN   32  datapath width
//  RADDR   5  register-address width
// PORTS
//  clk_i            in   1      rising-edge clock
//  rst_n_i          in   1      asynchronous active-low reset
//  stall_i          in   1      hold all stage registers (downstream/memory stall)
//  flush_i          in   1      replace next EX contents with a bubble (branch/jump redirect)
//  id_valid_i       in   1      ID holds a real instruction
//  id_rs1_data_i    in   XLEN   register-file read port 1
//  id_rs2_data_i    in   XLEN   register-file read port 2
//  id_imm_i         in   XLEN   sign-extended immediate
//  id_rs1_i/id_rs2_i/id_rd_i in RADDR  source/destination register numbers
//  id_funct3_i      in   3      instr[14:12]
//  id_funct7b5_i    in   1      instr[30]
//  id_aluop_i       in   2      00 LD/ST add, 01 branch sub, 10 R-type, 11 I-type ALU
//  id_alusrc_i      in   1      1: operand 2 = immediate
//  id_regwrite_i/id_memread_i/id_memwrite_i/id_memtoreg_i in 1  control bits
//  exmem_regwrite_i in 1; exmem_rd_i in RADDR; exmem_data_i in XLEN  EX/MEM forward source
//  memwb_regwrite_i in 1; memwb_rd_i in RADDR; memwb_data_i in XLEN  MEM/WB forward source
//  data1_o          out  XLEN   ALU operand 1 (forwarded rs1)
//  data2_o          out  XLEN   ALU operand 2 (imm or forwarded rs2)
//  alu_ctrl_o       out  4      ALU control code
//  store_data_o     out  XLEN   forwarded rs2, for stores
//  ex_rd_o          out  RADDR  registered rd
//  ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o  out 1
//  load_use_o       out  1      ID must hold this cycle (to PC and IF/ID enables)
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): all registers 0 -> ex_valid_o=0, all control outs 0,
//    alu_ctrl_o=ADD(4'b0010), data outs 0; load_use_o=0.
//  - Register update priority per rising edge: flush_i > stall_i (hold) > load_use_o (bubble) > capture.
//  - Bubble: valid/regwrite/memread/memwrite/memtoreg=0, rd=0, alu_ctrl=ADD; data fields don't-care.
//  - Latency: ID fields appear on EX outputs 1 cycle after capture.
//  - ALU ctrl decode (ID side, registered):
//    aluop 00->ADD, 01->SUB.
//    aluop 1x by funct3: 000 ADD (SUB iff aluop=10 & funct7b5), 001 SLL(9),
//      010/011 SLT(8), 100 XOR(3), 101 SRL(10)/SRA(11) by funct7b5, 110 OR(1), 111 AND(0).
//  - Forwarding (combinational on registered rs1/rs2):
//    EX/MEM match (regwrite & rd!=0 & rd==rs) beats MEM/WB match; else registered RF data.
//    x0 is never forwarded.
//  - load_use_o = ex_valid & ex_memread & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd).
//    Decoded from registered state, no combinational path from forward inputs.
//    Suppressed (0) while flush_i=1.
//  - stall_i held N cycles: outputs stable except forward muxes, which track forward inputs each cycle.
//  - Reset mid-stall or mid-hazard: state cleared immediately; no pending bubble survives reset.
// STRUCTURE
//  - Shared alu_pkg: ALU ctrl codes (ADD/SUB/AND/OR/XOR/SLT/SLL/SRL/SRA), aluop encodings,
//    XLEN/RADDR. Same package is used by the ALU.
//  - Sub-module alu_ctrl_decode: purely combinational aluop/funct3/funct7b5 -> 4-bit ctrl.
//  - Forward muxes and hazard detection stay in this module.
// TESTING
//  1. R-type sub: aluop=10,f3=000,f7b5=1, rs1=7,rs2=3 data 9/4, no fwd
//     -> next cycle alu_ctrl=6, data1=9, data2=4.
//  2. Double hazard: EX/MEM rd=5 data 0xAA, MEM/WB rd=5 data 0xBB, EX rs1=5 -> data1_o=0xAA.
//     Repeat with EX/MEM rd=0 -> data1_o unchanged (RF value); x0 never forwarded.
//  3. Load-use: lw x6 in EX, ID add rs2=x6 -> load_use_o=1; next edge EX holds bubble
//     (ex_valid=0, ctrl ADD); add captured on following edge.
//  4. flush_i & stall_i together -> bubble captured.
//     stall_i alone 3 cycles -> all registered outputs held constant.
//  5. I-type srai: aluop=11,f3=101,f7b5=1, alusrc=1, imm=2 -> alu_ctrl=11, data2_o=2.
//     addi with f7b5=1 -> ADD, not SUB.
//  6. Assert rst_n_i low mid-stall with valid instr in EX -> outputs zero asynchronously, load_use_o=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, aluop encodings and datapath widths.
// Also imported by the EX-stage ALU, so the codes here are the ALU's contract.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_XOR = 4'd3,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd8,
    ALU_SLL = 4'd9,
    ALU_SRL = 4'd10,
    ALU_SRA = 4'd11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of aluop/funct3/funct7b5 into the 4-bit ALU control code.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_ctrl_o
);

  // Map instruction class and function bits onto an ALU operation
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (aluop_i)
      ALUOP_MEM:    alu_ctrl_o = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // funct7b5 selects SUB only for R-type; on addi it is immediate bits
          3'b000: begin
            if ((aluop_i == ALUOP_RTYPE) && funct7b5_i) alu_ctrl_o = ALU_SUB;
            else                                        alu_ctrl_o = ALU_ADD;
          end
          3'b001: alu_ctrl_o = ALU_SLL;
          3'b010: alu_ctrl_o = ALU_SLT;
          3'b011: alu_ctrl_o = ALU_SLT;
          3'b100: alu_ctrl_o = ALU_XOR;
          3'b101: begin
            if (funct7b5_i) alu_ctrl_o = ALU_SRA;
            else            alu_ctrl_o = ALU_SRL;
          end
          3'b110: alu_ctrl_o = ALU_OR;
          3'b111: alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion,
// feeding final operands and control code to the EX-stage ALU.
module id_ex_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int RADDR = alu_pkg::RADDR
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [RADDR-1:0] id_rs1_i,
  input  logic [RADDR-1:0] id_rs2_i,
  input  logic [RADDR-1:0] id_rd_i,
  input  logic [2:0]       id_funct3_i,
  input  logic             id_funct7b5_i,
  input  logic [1:0]       id_aluop_i,
  input  logic             id_alusrc_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_memwrite_i,
  input  logic             id_memtoreg_i,
  input  logic             exmem_regwrite_i,
  input  logic [RADDR-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]  exmem_data_i,
  input  logic             memwb_regwrite_i,
  input  logic [RADDR-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]  memwb_data_i,
  output logic [XLEN-1:0]  data1_o,
  output logic [XLEN-1:0]  data2_o,
  output logic [3:0]       alu_ctrl_o,
  output logic [XLEN-1:0]  store_data_o,
  output logic [RADDR-1:0] ex_rd_o,
  output logic             ex_valid_o,
  output logic             ex_regwrite_o,
  output logic             ex_memread_o,
  output logic             ex_memwrite_o,
  output logic             ex_memtoreg_o,
  output logic             load_use_o
);

  logic [3:0]       id_alu_ctrl_s;
  logic             load_use_s;
  logic [XLEN-1:0]  fwd1_s;
  logic [XLEN-1:0]  fwd2_s;

  logic             ex_valid_r;
  logic             ex_regwrite_r;
  logic             ex_memread_r;
  logic             ex_memwrite_r;
  logic             ex_memtoreg_r;
  logic             ex_alusrc_r;
  logic [RADDR-1:0] ex_rd_r;
  logic [RADDR-1:0] ex_rs1_r;
  logic [RADDR-1:0] ex_rs2_r;
  logic [XLEN-1:0]  ex_rs1_data_r;
  logic [XLEN-1:0]  ex_rs2_data_r;
  logic [XLEN-1:0]  ex_imm_r;
  logic [3:0]       ex_alu_ctrl_r;

  alu_ctrl_decode u_alu_ctrl_decode (
    .aluop_i    (id_aluop_i),
    .funct3_i   (id_funct3_i),
    .funct7b5_i (id_funct7b5_i),
    .alu_ctrl_o (id_alu_ctrl_s)
  );

  // Load-use hazard: looks only at registered EX state and the ID fields
  always_comb begin
    load_use_s = 1'b0;
    if (flush_i) begin
      load_use_s = 1'b0;
    end else if (ex_valid_r && ex_memread_r && (ex_rd_r != {RADDR{1'b0}}) && id_valid_i &&
                 ((id_rs1_i == ex_rd_r) || (id_rs2_i == ex_rd_r))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Stage register: flush beats stall, stall beats the load-use bubble
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_r    <= 1'b0;
      ex_regwrite_r <= 1'b0;
      ex_memread_r  <= 1'b0;
      ex_memwrite_r <= 1'b0;
      ex_memtoreg_r <= 1'b0;
      ex_alusrc_r   <= 1'b0;
      ex_rd_r       <= {RADDR{1'b0}};
      ex_rs1_r      <= {RADDR{1'b0}};
      ex_rs2_r      <= {RADDR{1'b0}};
      ex_rs1_data_r <= {XLEN{1'b0}};
      ex_rs2_data_r <= {XLEN{1'b0}};
      ex_imm_r      <= {XLEN{1'b0}};
      ex_alu_ctrl_r <= ALU_ADD;
    end else if (flush_i || (!stall_i && load_use_s)) begin
      // Bubble also clears rs fields so a stale source can never pick up a forward
      ex_valid_r    <= 1'b0;
      ex_regwrite_r <= 1'b0;
      ex_memread_r  <= 1'b0;
      ex_memwrite_r <= 1'b0;
      ex_memtoreg_r <= 1'b0;
      ex_alusrc_r   <= 1'b0;
      ex_rd_r       <= {RADDR{1'b0}};
      ex_rs1_r      <= {RADDR{1'b0}};
      ex_rs2_r      <= {RADDR{1'b0}};
      ex_rs1_data_r <= {XLEN{1'b0}};
      ex_rs2_data_r <= {XLEN{1'b0}};
      ex_imm_r      <= {XLEN{1'b0}};
      ex_alu_ctrl_r <= ALU_ADD;
    end else if (!stall_i) begin
      ex_valid_r    <= id_valid_i;
      ex_regwrite_r <= id_regwrite_i;
      ex_memread_r  <= id_memread_i;
      ex_memwrite_r <= id_memwrite_i;
      ex_memtoreg_r <= id_memtoreg_i;
      ex_alusrc_r   <= id_alusrc_i;
      ex_rd_r       <= id_rd_i;
      ex_rs1_r      <= id_rs1_i;
      ex_rs2_r      <= id_rs2_i;
      ex_rs1_data_r <= id_rs1_data_i;
      ex_rs2_data_r <= id_rs2_data_i;
      ex_imm_r      <= id_imm_i;
      ex_alu_ctrl_r <= id_alu_ctrl_s;
    end
  end

  // Operand forwarding: the younger EX/MEM result wins; x0 is never forwarded
  always_comb begin
    fwd1_s = ex_rs1_data_r;
    if (exmem_regwrite_i && (exmem_rd_i != {RADDR{1'b0}}) && (exmem_rd_i == ex_rs1_r)) begin
      fwd1_s = exmem_data_i;
    end else if (memwb_regwrite_i && (memwb_rd_i != {RADDR{1'b0}}) && (memwb_rd_i == ex_rs1_r)) begin
      fwd1_s = memwb_data_i;
    end else begin
      fwd1_s = ex_rs1_data_r;
    end

    fwd2_s = ex_rs2_data_r;
    if (exmem_regwrite_i && (exmem_rd_i != {RADDR{1'b0}}) && (exmem_rd_i == ex_rs2_r)) begin
      fwd2_s = exmem_data_i;
    end else if (memwb_regwrite_i && (memwb_rd_i != {RADDR{1'b0}}) && (memwb_rd_i == ex_rs2_r)) begin
      fwd2_s = memwb_data_i;
    end else begin
      fwd2_s = ex_rs2_data_r;
    end
  end

  assign data1_o       = fwd1_s;
  assign data2_o       = ex_alusrc_r ? ex_imm_r : fwd2_s;
  assign store_data_o  = fwd2_s;
  assign alu_ctrl_o    = ex_alu_ctrl_r;
  assign ex_rd_o       = ex_rd_r;
  assign ex_valid_o    = ex_valid_r;
  assign ex_regwrite_o = ex_regwrite_r;
  assign ex_memread_o  = ex_memread_r;
  assign ex_memwrite_o = ex_memwrite_r;
  assign ex_memtoreg_o = ex_memtoreg_r;
  assign load_use_o    = load_use_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed stimulus pushes hand-computed
// expectations tagged with a cycle number; a negedge monitor pops and compares.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        stall_i, flush_i, id_valid_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0]  id_funct3_i;
  logic        id_funct7b5_i;
  logic [1:0]  id_aluop_i;
  logic        id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  ex_rd_o;
  logic        ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, load_use_o;

  id_ex_operand_stage dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_funct3_i(id_funct3_i), .id_funct7b5_i(id_funct7b5_i), .id_aluop_i(id_aluop_i),
    .id_alusrc_i(id_alusrc_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .data1_o(data1_o), .data2_o(data2_o), .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o),
    .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o),
    .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o),
    .load_use_o(load_use_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_EX = 0, K_DATA = 1, K_LU = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [4:0]  flags;   // valid, regwrite, memread, memwrite, memtoreg
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic [31:0] d1, d2, st;
    logic        lu;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;
  logic  drain_req = 1'b0;
  logic  drain_done = 1'b0;

  // Monitor: compare every expectation due this cycle against what the DUT presents
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    logic [4:0] act_flags;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      act_flags = {ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o};
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL %s: expectation missed, actual cycle %0d required cycle %0d", nm, cyc, e.cyc);
      end else if (e.kind == K_EX) begin
        if (act_flags !== e.flags || ex_rd_o !== e.rd || alu_ctrl_o !== e.ctrl) begin
          fails++;
          $display("FAIL %s: flags/rd/ctrl actual %b/%0d/%0d required %b/%0d/%0d",
                   nm, act_flags, ex_rd_o, alu_ctrl_o, e.flags, e.rd, e.ctrl);
        end
      end else if (e.kind == K_DATA) begin
        if (data1_o !== e.d1 || data2_o !== e.d2 || store_data_o !== e.st) begin
          fails++;
          $display("FAIL %s: data1/data2/store actual %h/%h/%h required %h/%h/%h",
                   nm, data1_o, data2_o, store_data_o, e.d1, e.d2, e.st);
        end
      end else begin
        if (load_use_o !== e.lu) begin
          fails++;
          $display("FAIL %s: load_use actual %b required %b", nm, load_use_o, e.lu);
        end
      end
    end
    if (drain_req && !drain_done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL drain: pending expectations actual %0d required 0", exp_q.size());
      end
      drain_done = 1'b1;
    end
  end

  task automatic push(input string nm, input exp_t e);
    e.cyc = cyc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic exp_ex(input string nm, input logic [4:0] flags, input logic [4:0] rd,
                        input logic [3:0] ctrl);
    exp_t e;
    e = '{cyc: 0, kind: K_EX, flags: flags, rd: rd, ctrl: ctrl,
          d1: 32'h0, d2: 32'h0, st: 32'h0, lu: 1'b0};
    push(nm, e);
  endtask

  task automatic exp_data(input string nm, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] st);
    exp_t e;
    e = '{cyc: 0, kind: K_DATA, flags: 5'b0, rd: 5'd0, ctrl: 4'd0,
          d1: d1, d2: d2, st: st, lu: 1'b0};
    push(nm, e);
  endtask

  task automatic exp_lu(input string nm, input logic lu);
    exp_t e;
    e = '{cyc: 0, kind: K_LU, flags: 5'b0, rd: 5'd0, ctrl: 4'd0,
          d1: 32'h0, d2: 32'h0, st: 32'h0, lu: lu};
    push(nm, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid_i = 1'b0; id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rd_i = 5'd0;
    id_rs1_data_i = 32'h0; id_rs2_data_i = 32'h0; id_imm_i = 32'h0;
    id_funct3_i = 3'd0; id_funct7b5_i = 1'b0; id_aluop_i = 2'b00; id_alusrc_i = 1'b0;
    id_regwrite_i = 1'b0; id_memread_i = 1'b0; id_memwrite_i = 1'b0; id_memtoreg_i = 1'b0;
  endtask

  task automatic id_drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                          input logic alusrc, input logic rw, input logic mr, input logic mtr);
    id_valid_i = 1'b1; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
    id_aluop_i = aluop; id_funct3_i = f3; id_funct7b5_i = f7; id_alusrc_i = alusrc;
    id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = 1'b0; id_memtoreg_i = mtr;
  endtask

  task automatic fwd(input logic erw, input logic [4:0] erd, input logic [31:0] ed,
                     input logic mrw, input logic [4:0] mrd, input logic [31:0] md);
    exmem_regwrite_i = erw; exmem_rd_i = erd; exmem_data_i = ed;
    memwb_regwrite_i = mrw; memwb_rd_i = mrd; memwb_data_i = md;
  endtask

  // aluop, funct3, funct7b5, expected control code
  logic [1:0] dec_op  [9] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
  logic [2:0] dec_f3  [9] = '{3'd0,  3'd2,  3'd3,  3'd4,  3'd1,  3'd5,  3'd5,  3'd6,  3'd7};
  logic       dec_f7  [9] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
  logic [3:0] dec_exp [9] = '{4'd6,  4'd8,  4'd8,  4'd3,  4'd9,  4'd10, 4'd11, 4'd1,  4'd0};

  initial begin
    rst_n_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    id_idle();
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(); step();
    exp_ex("reset_ctrl", 5'b00000, 5'd0, 4'd2);
    exp_data("reset_data", 32'h0, 32'h0, 32'h0);
    exp_lu("reset_lu", 1'b0);
    @(negedge clk); #1;
    rst_n_i = 1'b1;

    // R-type sub x8 = x7 - x3
    step();
    id_drive(5'd7, 5'd3, 5'd8, 32'd9, 32'd4, 32'h0, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    id_idle();
    exp_ex("rsub_ctrl", 5'b11000, 5'd8, 4'd6);
    exp_data("rsub_data", 32'd9, 32'd4, 32'd4);

    // Forward priority, checked across held cycles while stalled
    id_drive(5'd5, 5'd0, 5'd9, 32'h11, 32'h22, 32'h0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    id_idle();
    stall_i = 1'b1;
    fwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
    exp_data("fwd_exmem_wins", 32'hAA, 32'h22, 32'h22);
    step();
    fwd(1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
    exp_data("fwd_memwb", 32'hBB, 32'h22, 32'h22);
    step();
    fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    exp_data("fwd_x0_never", 32'h11, 32'h22, 32'h22);
    exp_ex("fwd_stall_ctrl", 5'b11000, 5'd9, 4'd2);
    step();
    stall_i = 1'b0;
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Load-use: lw x6 in EX, add with rs2=x6 in ID
    id_drive(5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'd4, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    id_drive(5'd2, 5'd6, 5'd7, 32'h30, 32'h40, 32'h0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_ex("lw_ctrl", 5'b11101, 5'd6, 4'd2);
    exp_data("lw_data", 32'h100, 32'd4, 32'h0);
    exp_lu("lu_detect", 1'b1);
    step();
    exp_ex("lu_bubble", 5'b00000, 5'd0, 4'd2);
    exp_lu("lu_clear", 1'b0);
    step();
    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h55);
    id_idle();
    exp_ex("lu_add_ctrl", 5'b11000, 5'd7, 4'd2);
    exp_data("lu_add_fwd", 32'h30, 32'h55, 32'h55);
    step();
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Flush together with stall captures a bubble
    id_drive(5'd7, 5'd3, 5'd8, 32'd9, 32'd4, 32'h0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    stall_i = 1'b0; flush_i = 1'b0;
    exp_ex("flush_stall_bubble", 5'b00000, 5'd0, 4'd2);

    // Stall alone holds registered outputs for three cycles
    id_drive(5'd3, 5'd4, 5'd10, 32'h1234, 32'h5678, 32'h0, 2'b11, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    stall_i = 1'b1;
    id_drive(5'd1, 5'd2, 5'd11, 32'hDEAD, 32'hBEEF, 32'h0, 2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_ex("stall_hold_ctrl", 5'b11000, 5'd10, 4'd1);
      exp_data("stall_hold_data", 32'h1234, 32'h5678, 32'h5678);
      step();
    end
    stall_i = 1'b0;

    // Flush suppresses load_use even with a live load hazard
    id_drive(5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'd4, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    id_drive(5'd6, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush_i = 1'b1;
    exp_lu("flush_suppress_lu", 1'b0);
    step();
    flush_i = 1'b0;
    id_idle();
    exp_ex("flush_bubble", 5'b00000, 5'd0, 4'd2);

    // I-type srai and addi with funct7b5 set
    id_drive(5'd2, 5'd0, 5'd12, 32'h80, 32'h0, 32'd2, 2'b11, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    id_drive(5'd2, 5'd0, 5'd12, 32'h80, 32'h0, 32'd5, 2'b11, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_ex("srai_ctrl", 5'b11000, 5'd12, 4'd11);
    exp_data("srai_data", 32'h80, 32'd2, 32'h0);
    step();
    id_idle();
    exp_ex("addi_f7_ctrl", 5'b11000, 5'd12, 4'd2);
    exp_data("addi_f7_data", 32'h80, 32'd5, 32'h0);

    // Decode table sweep
    for (int i = 0; i < 9; i++) begin
      id_drive(5'd1, 5'd2, 5'd13, 32'h0, 32'h0, 32'h0, dec_op[i], dec_f3[i], dec_f7[i],
               1'b0, 1'b1, 1'b0, 1'b0);
      step();
      id_idle();
      exp_ex("decode_sweep", 5'b11000, 5'd13, dec_exp[i]);
    end

    // Async reset while stalled with a load hazard pending
    id_drive(5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'd4, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    stall_i = 1'b1;
    id_drive(5'd2, 5'd6, 5'd7, 32'h30, 32'h40, 32'h0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_lu("pre_reset_lu", 1'b1);
    step();
    rst_n_i = 1'b0;
    exp_ex("async_reset_ctrl", 5'b00000, 5'd0, 4'd2);
    exp_data("async_reset_data", 32'h0, 32'h0, 32'h0);
    exp_lu("async_reset_lu", 1'b0);
    step();
    rst_n_i = 1'b1;
    stall_i = 1'b0;
    id_idle();
    step();
    exp_ex("post_reset_idle", 5'b00000, 5'd0, 4'd2);
    step();

    drain_req = 1'b1;
    for (int i = 0; i < 10 && !drain_done; i++) @(posedge clk);
    if (!drain_done) begin
      $display("FAIL drain_timeout: monitor actual not-done required done");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    end else begin
      $display("[TB] %0d tests run, %0d failed", tests, fails);
    end
    $finish;
  end

endmodule
